// File: rtl/spi_reg_responder.sv
// SPI mode-0 slave over a 32x8 register file with a local fabric port; loc_rdata 1 clk, SPI edges act 3 clks after the pin.
// No backpressure: every completed SPI write byte emits a one-cycle spi_wr_valid pulse that cannot be stalled.
module spi_reg_responder #(
    parameter int STATUS_REG  = 25,
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_sclk,
    input  logic       i_ss_n,
    input  logic       i_mosi,
    output logic       o_miso,
    output logic       o_miso_oe,
    input  logic       i_loc_we,
    input  logic [4:0] i_loc_addr,
    input  logic [7:0] i_loc_wdata,
    output logic [7:0] o_loc_rdata,
    output logic       o_spi_wr_valid,
    output logic [4:0] o_spi_wr_addr,
    output logic [7:0] o_spi_wr_data
);

    localparam logic [4:0] LP_STATUS = 5'(STATUS_REG);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_ss_d;
    logic [2:0]             r_bit_cnt;
    logic [6:0]             r_rx_shift;
    logic [7:0]             r_tx_shift;
    logic [4:0]             r_addr;
    logic                   r_dir;
    logic                   r_miso_oe;
    logic                   r_spi_wr_valid;
    logic [4:0]             r_spi_wr_addr;
    logic [7:0]             r_spi_wr_data;
    logic [7:0]             r_loc_rdata;
    logic [7:0]             r_regs [32];

    logic       w_sclk;
    logic       w_ss;
    logic       w_mosi;
    logic       w_sclk_rise;
    logic       w_sclk_fall;
    logic       w_ss_rise;
    logic       w_ss_fall;
    logic       w_byte_done;
    logic [7:0] w_rx_byte;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss        = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_ss_rise   = w_ss & ~r_ss_d;
    assign w_ss_fall   = ~w_ss & r_ss_d;
    assign w_rx_byte   = {r_rx_shift, w_mosi};
    assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7) && (r_state != S_IDLE);

    // ss_n synchronizer resets high so reset release never looks like a select.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_ss_d      <= 1'b1;
        end else begin
            r_sclk_sync <= (r_sclk_sync << 1) | SYNC_STAGES'(i_sclk);
            r_ss_sync   <= (r_ss_sync << 1) | SYNC_STAGES'(i_ss_n);
            r_mosi_sync <= (r_mosi_sync << 1) | SYNC_STAGES'(i_mosi);
            r_sclk_d    <= w_sclk;
            r_ss_d      <= w_ss;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_ss_rise) begin
            w_state_nxt = S_IDLE;
        end else if (w_ss_fall && (r_state == S_IDLE)) begin
            w_state_nxt = S_CMD;
        end else if ((r_state == S_CMD) && w_byte_done) begin
            w_state_nxt = S_DATA;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_bit_cnt      <= 3'd0;
            r_rx_shift     <= 7'd0;
            r_tx_shift     <= 8'd0;
            r_addr         <= 5'd0;
            r_dir          <= 1'b0;
            r_miso_oe      <= 1'b0;
            r_spi_wr_valid <= 1'b0;
            r_spi_wr_addr  <= 5'd0;
            r_spi_wr_data  <= 8'd0;
            r_loc_rdata    <= 8'd0;
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 8'd0;
            end
        end else begin
            r_spi_wr_valid <= 1'b0;
            if (w_ss_rise) begin
                r_miso_oe <= 1'b0;
                r_bit_cnt <= 3'd0;
            end else if (w_ss_fall && (r_state == S_IDLE)) begin
                r_tx_shift <= r_regs[LP_STATUS];
                r_bit_cnt  <= 3'd0;
                r_miso_oe  <= 1'b1;
            end else if (r_state != S_IDLE) begin
                if (w_sclk_rise) begin
                    r_rx_shift <= w_rx_byte[6:0];
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                    if (w_byte_done && (r_state == S_CMD)) begin
                        r_addr <= w_rx_byte[7:3];
                        r_dir  <= w_rx_byte[1];
                    end else if (w_byte_done && r_dir) begin
                        r_regs[r_addr] <= w_rx_byte;
                        r_spi_wr_valid <= 1'b1;
                        r_spi_wr_addr  <= r_addr;
                        r_spi_wr_data  <= w_rx_byte;
                        r_addr         <= r_addr + 5'd1;
                    end
                end else if (w_sclk_fall) begin
                    // Byte boundary in DATA: present reg[addr]; reads consume the address here.
                    if ((r_bit_cnt == 3'd0) && (r_state == S_DATA)) begin
                        r_tx_shift <= r_regs[r_addr];
                        if (!r_dir) begin
                            r_addr <= r_addr + 5'd1;
                        end
                    end else begin
                        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                    end
                end
            end
            // Placed after the SPI write so a same-cycle local write to the same address wins.
            if (i_loc_we) begin
                r_regs[i_loc_addr] <= i_loc_wdata;
            end
            r_loc_rdata <= r_regs[i_loc_addr];
        end
    end

    assign o_miso         = r_tx_shift[7];
    assign o_miso_oe      = r_miso_oe;
    assign o_loc_rdata    = r_loc_rdata;
    assign o_spi_wr_valid = r_spi_wr_valid;
    assign o_spi_wr_addr  = r_spi_wr_addr;
    assign o_spi_wr_data  = r_spi_wr_data;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Scoreboard bench for spi_reg_responder: expected MISO bytes and SPI write reports are queued, monitors pop and compare.
module tb_spi_reg_responder;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sclk = 1'b0;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic       loc_we = 1'b0;
    logic [4:0] loc_addr = 5'd0;
    logic [7:0] loc_wdata = 8'd0;
    logic [7:0] loc_rdata;
    logic       spi_wr_valid;
    logic [4:0] spi_wr_addr;
    logic [7:0] spi_wr_data;

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_wr_seen = 0;
    logic [12:0] wr_exp_q[$];
    logic [7:0]  miso_exp_q[$];
    logic        rx_vld = 1'b0;
    logic [7:0]  rx_byte = 8'd0;

    spi_reg_responder #(.STATUS_REG(25), .SYNC_STAGES(2)) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_sclk        (sclk),
        .i_ss_n        (ss_n),
        .i_mosi        (mosi),
        .o_miso        (miso),
        .o_miso_oe     (miso_oe),
        .i_loc_we      (loc_we),
        .i_loc_addr    (loc_addr),
        .i_loc_wdata   (loc_wdata),
        .o_loc_rdata   (loc_rdata),
        .o_spi_wr_valid(spi_wr_valid),
        .o_spi_wr_addr (spi_wr_addr),
        .o_spi_wr_data (spi_wr_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Monitor for SPI write reports.
    always @(negedge clk) begin
        if (spi_wr_valid === 1'b1) begin
            logic [12:0] e;
            n_wr_seen++;
            if (wr_exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wr_unexpected: addr %0d data 0x%02h with nothing expected", spi_wr_addr, spi_wr_data);
            end else begin
                e = wr_exp_q.pop_front();
                check("wr_addr", 8'(spi_wr_addr), 8'(e[12:8]));
                check("wr_data", spi_wr_data, e[7:0]);
            end
        end
    end

    // Monitor for bytes the master captured on MISO.
    always @(posedge clk) begin
        if (rx_vld) begin
            if (miso_exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL miso_unexpected: got 0x%02h with nothing expected", rx_byte);
            end else begin
                check("miso_byte", rx_byte, miso_exp_q.pop_front());
            end
        end
    end

    task automatic loc_write(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        loc_we = 1'b1; loc_addr = a; loc_wdata = d;
        @(negedge clk);
        loc_we = 1'b0;
    endtask

    task automatic loc_read(input logic [4:0] a, input logic [7:0] exp);
        @(negedge clk);
        loc_addr = a;
        @(posedge clk);
        @(negedge clk);
        check("loc_rdata", loc_rdata, exp);
    endtask

    task automatic ss_low();
        @(negedge clk);
        ss_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic ss_high();
        repeat (2) @(negedge clk);
        ss_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic push_wr(input logic [4:0] a, input logic [7:0] d);
        wr_exp_q.push_back({a, d});
    endtask

    // Mode-0 master: 8 clk sclk period; optional local write timed onto the last rising edge's action cycle.
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, input bit chk,
                            input logic [7:0] exp, input bit collide);
        logic [7:0] rx;
        rx = 8'd0;
        if (chk) miso_exp_q.push_back(exp);
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = tx[i];
            repeat (4) @(negedge clk);
            rx[i] = miso;
            sclk = 1'b1;
            if (collide && i == 0) begin
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                loc_we = 1'b1; loc_addr = 5'd7; loc_wdata = 8'h99;
                @(negedge clk);
                loc_we = 1'b0;
                repeat (2) @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
            sclk = 1'b0;
        end
        if (chk) begin
            rx_byte = rx;
            rx_vld = 1'b1;
            @(negedge clk);
            rx_vld = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(negedge clk);
        check("rst_miso", 8'(miso), 8'h00);
        check("rst_miso_oe", 8'(miso_oe), 8'h00);
        check("rst_loc_rdata", loc_rdata, 8'h00);
        check("rst_wr_valid", 8'(spi_wr_valid), 8'h00);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Status register on MISO during command, then reg1 (reset value).
        loc_write(5'd25, 8'hA5);
        ss_low();
        check("oe_active", 8'(miso_oe), 8'h01);
        spi_xfer(8'h08, 8, 1, 8'hA5, 0);
        spi_xfer(8'h00, 8, 1, 8'h00, 0);
        ss_high();
        check("oe_released", 8'(miso_oe), 8'h00);

        // Write burst wrapping 30 -> 31 -> 0.
        ss_low();
        spi_xfer(8'hF2, 8, 1, 8'hA5, 0);
        push_wr(5'd30, 8'h11); spi_xfer(8'h11, 8, 0, 8'h00, 0);
        push_wr(5'd31, 8'h22); spi_xfer(8'h22, 8, 0, 8'h00, 0);
        push_wr(5'd0,  8'h33); spi_xfer(8'h33, 8, 0, 8'h00, 0);
        ss_high();
        loc_read(5'd30, 8'h11);
        loc_read(5'd31, 8'h22);
        loc_read(5'd0,  8'h33);

        // Read burst from preloaded registers.
        loc_write(5'd4, 8'h04);
        loc_write(5'd5, 8'hDE);
        ss_low();
        spi_xfer(8'h20, 8, 1, 8'hA5, 0);
        spi_xfer(8'h00, 8, 1, 8'h04, 0);
        spi_xfer(8'h00, 8, 1, 8'hDE, 0);
        ss_high();

        // Abort a write byte after 5 bits.
        ss_low();
        spi_xfer(8'h1A, 8, 1, 8'hA5, 0);
        spi_xfer(8'hFF, 5, 0, 8'h00, 0);
        ss_high();
        check("abort_oe", 8'(miso_oe), 8'h00);
        loc_read(5'd3, 8'h00);

        // Same-cycle SPI and local write to reg7.
        ss_low();
        spi_xfer(8'h3A, 8, 1, 8'hA5, 0);
        push_wr(5'd7, 8'h55);
        spi_xfer(8'h55, 8, 0, 8'h00, 1);
        ss_high();
        loc_read(5'd7, 8'h99);

        // Async reset in the middle of a data byte.
        ss_low();
        spi_xfer(8'h42, 8, 1, 8'hA5, 0);
        spi_xfer(8'hAB, 4, 0, 8'h00, 0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_miso_oe", 8'(miso_oe), 8'h00);
        check("mid_rst_miso", 8'(miso), 8'h00);
        check("mid_rst_loc_rdata", loc_rdata, 8'h00);
        check("mid_rst_wr_valid", 8'(spi_wr_valid), 8'h00);
        check("mid_rst_wr_addr", 8'(spi_wr_addr), 8'h00);
        check("mid_rst_wr_data", spi_wr_data, 8'h00);
        ss_n = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        loc_read(5'd30, 8'h00);

        ss_low();
        spi_xfer(8'h12, 8, 1, 8'h00, 0);
        push_wr(5'd2, 8'h77);
        spi_xfer(8'h77, 8, 0, 8'h00, 0);
        ss_high();
        ss_low();
        spi_xfer(8'h10, 8, 1, 8'h00, 0);
        spi_xfer(8'h00, 8, 1, 8'h77, 0);
        ss_high();
        loc_read(5'd2, 8'h77);

        repeat (4) @(negedge clk);
        check("wr_pulse_count", 8'(n_wr_seen), 8'd5);
        check("wr_queue_left", 8'(wr_exp_q.size()), 8'd0);
        check("miso_queue_left", 8'(miso_exp_q.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
